// File: rtl/instr_encoder.sv
// RV32I field-to-word encoder: packs opcode/register/funct/immediate fields into
// instruction words and streams them through a small FIFO to an imem write port.
module instr_encoder #(
   parameter int DEPTH     = 4,
   parameter int ADDR_W    = 10,
   parameter int BASE_ADDR = 0
) (
   input  logic                       clk,
   input  logic                       nReset,
   input  logic                       start,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [4:0]                 in_opcode,
   input  logic [4:0]                 in_rd,
   input  logic [4:0]                 in_rs1,
   input  logic [4:0]                 in_rs2,
   input  logic [2:0]                 in_funct3,
   input  logic                       in_f7b5,
   input  logic [31:0]                in_imm,
   output logic                       wr_en,
   output logic [ADDR_W-1:0]          wr_addr,
   output logic [31:0]                wr_data,
   input  logic                       wr_ready,
   output logic                       illegal,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       busy
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);
   localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

   localparam logic [4:0] OPC_LOAD   = 5'b00000;
   localparam logic [4:0] OPC_OPIMM  = 5'b00100;
   localparam logic [4:0] OPC_AUIPC  = 5'b00101;
   localparam logic [4:0] OPC_STORE  = 5'b01000;
   localparam logic [4:0] OPC_OP     = 5'b01100;
   localparam logic [4:0] OPC_LUI    = 5'b01101;
   localparam logic [4:0] OPC_BRANCH = 5'b11000;
   localparam logic [4:0] OPC_JALR   = 5'b11001;
   localparam logic [4:0] OPC_JAL    = 5'b11011;

   logic [31:0]       mem_q [DEPTH];
   logic [PTR_W-1:0]  wptr_q, wptr_d;
   logic [PTR_W-1:0]  rptr_q, rptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              illegal_q, illegal_d;

   logic [31:0] enc_word;
   logic        enc_legal;
   logic [6:0]  opc7;
   logic        full, empty, xfer, push, pop;

   assign opc7 = {in_opcode, 2'b11};

   always_comb begin
      enc_word  = '0;
      enc_legal = 1'b1;
      case (in_opcode)
         OPC_LUI, OPC_AUIPC:
            enc_word = {in_imm[31:12], in_rd, opc7};
         OPC_OPIMM: begin
            // shift-immediates carry SRAI select in funct7 and shamt in imm[4:0]
            if (in_funct3 == 3'b001 || in_funct3 == 3'b101)
               enc_word = {1'b0, in_f7b5, 5'b00000, in_imm[4:0], in_rs1, in_funct3, in_rd, opc7};
            else
               enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, opc7};
         end
         OPC_LOAD:
            enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, opc7};
         OPC_JALR:
            enc_word = {in_imm[11:0], in_rs1, 3'b000, in_rd, opc7};
         OPC_OP:
            enc_word = {1'b0, in_f7b5, 5'b00000, in_rs2, in_rs1, in_funct3, in_rd, opc7};
         OPC_STORE: begin
            enc_word  = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], opc7};
            enc_legal = (in_funct3 <= 3'b010);
         end
         OPC_BRANCH: begin
            enc_word  = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                         in_imm[4:1], in_imm[11], opc7};
            enc_legal = !(in_funct3 == 3'b010 || in_funct3 == 3'b011);
         end
         OPC_JAL:
            enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, opc7};
         default:
            enc_legal = 1'b0;
      endcase
   end

   assign full     = (count_q == CNT_W'(DEPTH));
   assign empty    = (count_q == '0);
   assign in_ready = nReset && !full && !start;
   assign xfer     = in_valid && in_ready;
   assign push     = xfer && enc_legal;
   assign wr_en    = nReset && !empty;
   assign pop      = wr_en && wr_ready;

   always_comb begin
      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
      wptr_d    = push ? wptr_q + PTR_W'(1) : wptr_q;
      rptr_d    = pop  ? rptr_q + PTR_W'(1) : rptr_q;
      addr_d    = pop  ? addr_q + ADDR_W'(1) : addr_q;
      illegal_d = xfer && !enc_legal;
   end

   // start shares the reset path so a flush also drops a write accepted that cycle
   always_ff @(posedge clk) begin
      if (!nReset || start) begin
         count_q   <= '0;
         wptr_q    <= '0;
         rptr_q    <= '0;
         addr_q    <= BASE;
         illegal_q <= 1'b0;
      end else begin
         count_q   <= count_d;
         wptr_q    <= wptr_d;
         rptr_q    <= rptr_d;
         addr_q    <= addr_d;
         illegal_q <= illegal_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push)
         mem_q[wptr_q] <= enc_word;
   end

   assign wr_addr = addr_q;
   assign wr_data = wr_en ? mem_q[rptr_q] : 32'h0;
   assign illegal = illegal_q;
   assign count   = count_q;
   assign busy    = wr_en;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed-vector bench for instr_encoder: encoding table, backpressure, illegal
// pulses, address wrap (second instance with ADDR_W=2), start and reset flushes.
module tb_instr_encoder;

   logic        clk = 1'b0;
   logic        nReset, start, in_valid, wr_ready;
   logic [4:0]  in_opcode, in_rd, in_rs1, in_rs2;
   logic [2:0]  in_funct3;
   logic        in_f7b5;
   logic [31:0] in_imm;

   logic        in_ready, wr_en, illegal, busy;
   logic [9:0]  wr_addr;
   logic [31:0] wr_data;
   logic [2:0]  count;

   logic        in_ready_w, wr_en_w, illegal_w, busy_w;
   logic [1:0]  wr_addr_w;
   logic [31:0] wr_data_w;
   logic [2:0]  count_w;

   always #5 clk = ~clk;

   instr_encoder #(.DEPTH(4), .ADDR_W(10), .BASE_ADDR(0)) dut (
      .clk(clk), .nReset(nReset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
      .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
      .in_funct3(in_funct3), .in_f7b5(in_f7b5), .in_imm(in_imm),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
      .illegal(illegal), .count(count), .busy(busy)
   );

   instr_encoder #(.DEPTH(4), .ADDR_W(2), .BASE_ADDR(0)) dut_w (
      .clk(clk), .nReset(nReset), .start(start), .in_valid(in_valid), .in_ready(in_ready_w),
      .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
      .in_funct3(in_funct3), .in_f7b5(in_f7b5), .in_imm(in_imm),
      .wr_en(wr_en_w), .wr_addr(wr_addr_w), .wr_data(wr_data_w), .wr_ready(wr_ready),
      .illegal(illegal_w), .count(count_w), .busy(busy_w)
   );

   typedef struct {
      logic [4:0]  op;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [2:0]  f3;
      logic        f7b5;
      logic [31:0] imm;
      logic [31:0] exp;
      logic        ill;
   } vec_t;

   localparam int NV = 16;
   vec_t tbl [NV];

   int          n_vec = 0;
   int          n_err = 0;
   logic [31:0] exp_q [$];
   logic [9:0]  exp_addr = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic drive(input vec_t v);
      in_opcode = v.op;  in_rd = v.rd;    in_rs1 = v.rs1; in_rs2 = v.rs2;
      in_funct3 = v.f3;  in_f7b5 = v.f7b5; in_imm = v.imm;
   endtask

   // one field set with wr_ready=1: word must show up the cycle after transfer
   task automatic apply(input vec_t v);
      logic [9:0] a;
      @(negedge clk); drive(v); in_valid = 1'b1; #2;
      a = exp_addr;
      chk("in_ready", in_ready, 1);
      if (!v.ill) exp_q.push_back(v.exp);
      @(negedge clk); in_valid = 1'b0; #2;
      chk("illegal", illegal, v.ill);
      chk("illegal_w2", illegal_w, v.ill);
      chk("wr_en_next", wr_en, !v.ill);
      if (!v.ill) chk("wr_data_next", wr_data, v.exp);
      @(negedge clk); #2;
      chk("illegal_pulse_end", illegal, 0);
      chk("count_drained", count, 0);
      if (v.ill) chk("illegal_addr_hold", wr_addr, a);
   endtask

   task automatic push_stalled(input vec_t v);
      @(negedge clk); drive(v); in_valid = 1'b1; #2;
      chk("stall_push_ready", in_ready, 1);
      exp_q.push_back(v.exp);
   endtask

   task automatic wait_drain();
      for (int c = 0; c < 20; c++) begin
         @(negedge clk); #2;
         if (count == 0) break;
      end
      chk("drain_count", count, 0);
      chk("drain_count_w2", count_w, 0);
   endtask

   // write-out scoreboard: order, data, address (incl. 2-bit wrapped copy)
   always begin
      @(negedge clk); #2;
      if (!nReset || start) begin
         exp_q.delete();
         exp_addr = '0;
      end else if (wr_en && exp_q.size() == 0) begin
         chk("spurious_wr_en", wr_en, 0);
      end else if (wr_en && wr_ready) begin
         chk("wr_data", wr_data, exp_q[0]);
         chk("wr_addr", wr_addr, exp_addr);
         chk("wr_data_w2", wr_data_w, exp_q[0]);
         chk("wr_addr_w2", wr_addr_w, exp_addr[1:0]);
         void'(exp_q.pop_front());
         exp_addr = exp_addr + 10'd1;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: run did not finish, got timeout expected $finish");
      $fatal(1);
   end

   initial begin
      //           op        rd     rs1    rs2    f3     f7b5  imm            exp            ill
      tbl[0]  = '{5'b00100, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'hFFFFFFFF, 32'hFFF00093, 1'b0};
      tbl[1]  = '{5'b01101, 5'd5, 5'd0, 5'd0, 3'd0, 1'b0, 32'h12345000, 32'h123452B7, 1'b0};
      tbl[2]  = '{5'b11000, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, 32'hFFFFFFFC, 32'hFE208EE3, 1'b0};
      tbl[3]  = '{5'b11011, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'h00000008, 32'h008000EF, 1'b0};
      tbl[4]  = '{5'b01000, 5'd0, 5'd1, 5'd2, 3'd2, 1'b0, 32'h00000008, 32'h0020A423, 1'b0};
      tbl[5]  = '{5'b00100, 5'd3, 5'd3, 5'd0, 3'd5, 1'b1, 32'h00000004, 32'h4041D193, 1'b0};
      tbl[6]  = '{5'b00100, 5'd3, 5'd3, 5'd0, 3'd0, 1'b1, 32'h00000004, 32'h00418193, 1'b0};
      tbl[7]  = '{5'b01100, 5'd3, 5'd1, 5'd2, 3'd0, 1'b1, 32'h00000000, 32'h402081B3, 1'b0};
      tbl[8]  = '{5'b00101, 5'd2, 5'd0, 5'd0, 3'd0, 1'b0, 32'h00001000, 32'h00001117, 1'b0};
      tbl[9]  = '{5'b11001, 5'd1, 5'd5, 5'd0, 3'd7, 1'b0, 32'h00000010, 32'h010280E7, 1'b0};
      tbl[10] = '{5'b00000, 5'd6, 5'd2, 5'd0, 3'd2, 1'b0, 32'hFFFFFFF8, 32'hFF812303, 1'b0};
      tbl[11] = '{5'b01101, 5'd5, 5'd0, 5'd0, 3'd0, 1'b0, 32'h12345ABC, 32'h123452B7, 1'b0};
      tbl[12] = '{5'b00011, 5'd1, 5'd1, 5'd1, 3'd0, 1'b0, 32'h00000000, 32'h00000000, 1'b1};
      tbl[13] = '{5'b11000, 5'd0, 5'd1, 5'd2, 3'd2, 1'b0, 32'h00000008, 32'h00000000, 1'b1};
      tbl[14] = '{5'b11000, 5'd0, 5'd1, 5'd2, 3'd3, 1'b0, 32'h00000008, 32'h00000000, 1'b1};
      tbl[15] = '{5'b01000, 5'd0, 5'd1, 5'd2, 3'd3, 1'b0, 32'h00000008, 32'h00000000, 1'b1};

      nReset = 1'b0; start = 1'b0; in_valid = 1'b0; wr_ready = 1'b0;
      drive(tbl[0]);
      repeat (2) @(negedge clk);
      #2;
      chk("rst_in_ready", in_ready, 0);
      chk("rst_wr_en", wr_en, 0);
      chk("rst_busy", busy, 0);
      chk("rst_count", count, 0);
      chk("rst_wr_addr", wr_addr, 0);
      chk("rst_wr_data", wr_data, 0);
      chk("rst_illegal", illegal, 0);
      chk("rst_wr_en_w2", wr_en_w, 0);
      chk("rst_in_ready_w2", in_ready_w, 0);

      @(negedge clk); nReset = 1'b1; wr_ready = 1'b1;
      for (int i = 0; i < NV; i++) apply(tbl[i]);

      // backpressure: fill, stall, release; fifth word waits for space
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0; wr_ready = 1'b0;
      for (int i = 0; i < 4; i++) push_stalled(tbl[i]);
      @(negedge clk); drive(tbl[4]); #2;
      chk("full_count", count, 4);
      chk("full_count_w2", count_w, 4);
      chk("full_in_ready", in_ready, 0);
      chk("full_busy", busy, 1);
      chk("full_busy_w2", busy_w, 1);
      repeat (3) begin
         @(negedge clk); #2;
         chk("stall_wr_en", wr_en, 1);
         chk("stall_addr", wr_addr, 0);
         chk("stall_data", wr_data, tbl[0].exp);
      end
      @(negedge clk); wr_ready = 1'b1; #2;
      chk("full_no_bypass", in_ready, 0);
      @(negedge clk); #2;
      chk("space_freed", in_ready, 1);
      exp_q.push_back(tbl[4].exp);
      @(negedge clk); in_valid = 1'b0;
      wait_drain();

      // start with three queued and a pending write
      @(negedge clk); wr_ready = 1'b0;
      for (int i = 5; i < 8; i++) push_stalled(tbl[i]);
      @(negedge clk); drive(tbl[8]); in_valid = 1'b1; start = 1'b1; wr_ready = 1'b1; #2;
      chk("start_blocks_in", in_ready, 0);
      @(negedge clk); start = 1'b0; in_valid = 1'b0; wr_ready = 1'b0; #2;
      chk("start_count", count, 0);
      chk("start_wr_en", wr_en, 0);
      chk("start_addr", wr_addr, 0);
      chk("start_addr_w2", wr_addr_w, 0);
      chk("start_busy", busy, 0);
      wr_ready = 1'b1;
      apply(tbl[8]);

      // same with reset instead of start
      @(negedge clk); wr_ready = 1'b0;
      for (int i = 9; i < 12; i++) push_stalled(tbl[i]);
      @(negedge clk); drive(tbl[1]); in_valid = 1'b1; nReset = 1'b0; wr_ready = 1'b1; #2;
      chk("rst_mid_in_ready", in_ready, 0);
      chk("rst_mid_wr_en", wr_en, 0);
      chk("rst_mid_busy", busy, 0);
      @(negedge clk); nReset = 1'b1; in_valid = 1'b0; wr_ready = 1'b0; #2;
      chk("rst_mid_count", count, 0);
      chk("rst_mid_addr", wr_addr, 0);
      chk("rst_mid_addr_w2", wr_addr_w, 0);
      chk("rst_mid_data", wr_data, 0);
      wr_ready = 1'b1;
      apply(tbl[1]);
      wait_drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
